adder_tree_operand_loader: RTL and testbench

Upstream feeder for the 3-level, 128-bit adder tree top. It accepts a serial valid/ready stream of 128-bit operand words and collects up to eight of them into a fill bank. It then transfers them in one edge to the eight parallel operand lanes that the tree registers every clock. It also generates a launch strobe, and a result-valid strobe aligned to the tree's registered sum, so downstream logic knows which tree output cycle carries a fresh result.

---
 rtl/adder_tree_pkg.sv | 14 +
 rtl/adder_tree_lane_bank.sv | 30 +++
 rtl/adder_tree_operand_loader.sv | 153 +++++++++++++++
 tb/tb_adder_tree_operand_loader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the 3-level adder tree and its operand loader.
package adder_tree_pkg;

    localparam int unsigned ADDER_WIDTH = 128;
    localparam int unsigned LANES       = 8;

    typedef logic [2:0] lane_idx_t;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/adder_tree_lane_bank.sv
// Register bank of DEPTH operand words: indexed write, synchronous clear, parallel read.
module adder_tree_lane_bank
    import adder_tree_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH,
    parameter int unsigned DEPTH = LANES
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         wr_en,
    input  lane_idx_t                    wr_idx,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [DEPTH-1:0][WIDTH-1:0]  rd_data
);

    logic [DEPTH-1:0][WIDTH-1:0] bank;

    // Clear wins over write so a transfer edge always leaves an empty bank.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            bank <= '0;
        end else if (wr_en) begin
            bank[wr_idx] <= wr_data;
        end
    end

    assign rd_data = bank;

endmodule

// File: rtl/adder_tree_operand_loader.sv
// Collects a serial operand stream into eight parallel adder-tree lanes and tracks result validity.
module adder_tree_operand_loader #(
    parameter int unsigned ADDER_WIDTH  = adder_tree_pkg::ADDER_WIDTH,
    parameter int unsigned LANES        = adder_tree_pkg::LANES,
    parameter int unsigned TREE_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH-1:0] in_data,
    input  logic                   in_last,
    input  logic                   stall,
    output logic [ADDER_WIDTH-1:0] isum0_0_0_0,
    output logic [ADDER_WIDTH-1:0] isum0_0_0_1,
    output logic [ADDER_WIDTH-1:0] isum0_0_1_0,
    output logic [ADDER_WIDTH-1:0] isum0_0_1_1,
    output logic [ADDER_WIDTH-1:0] isum0_1_0_0,
    output logic [ADDER_WIDTH-1:0] isum0_1_0_1,
    output logic [ADDER_WIDTH-1:0] isum0_1_1_0,
    output logic [ADDER_WIDTH-1:0] isum0_1_1_1,
    output logic                   launch,
    output logic [3:0]             launch_count,
    output logic                   sum_valid
);

    import adder_tree_pkg::*;

    loader_state_t state, state_next;
    lane_idx_t     cnt, cnt_next;
    logic [3:0]    held_count, held_count_next;
    logic [3:0]    count_next;

    logic accept;
    logic closing;
    logic transfer;
    logic bank_wr;
    logic bank_clear;

    logic [LANES-1:0][ADDER_WIDTH-1:0] bank_q;
    logic [LANES-1:0][ADDER_WIDTH-1:0] merged;
    logic [LANES-1:0][ADDER_WIDTH-1:0] lanes;

    logic                    launch_q;
    logic [TREE_LATENCY-1:0] sv_pipe;

    assign in_ready = rst_n && (state == FILL);
    assign accept   = in_valid && in_ready;
    assign closing  = accept && ((cnt == lane_idx_t'(LANES - 1)) || in_last);

    adder_tree_lane_bank #(
        .WIDTH (ADDER_WIDTH),
        .DEPTH (LANES)
    ) u_fill_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (bank_clear),
        .wr_en   (bank_wr),
        .wr_idx  (cnt),
        .wr_data (in_data),
        .rd_data (bank_q)
    );

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        held_count_next = held_count;
        count_next      = held_count;
        transfer        = 1'b0;
        bank_wr         = 1'b0;
        bank_clear      = 1'b0;
        case (state)
            FILL: begin
                if (accept) begin
                    if (closing && !stall) begin
                        transfer   = 1'b1;
                        bank_clear = 1'b1;
                        cnt_next   = '0;
                        count_next = {1'b0, cnt} + 4'd1;
                    end else if (closing) begin
                        bank_wr         = 1'b1;
                        state_next      = FULL;
                        held_count_next = {1'b0, cnt} + 4'd1;
                        cnt_next        = '0;
                    end else begin
                        bank_wr  = 1'b1;
                        cnt_next = cnt + 3'd1;
                    end
                end
            end
            FULL: begin
                if (!stall) begin
                    transfer   = 1'b1;
                    bank_clear = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    // On a FILL-state close the incoming word bypasses the bank; lanes past it are zeroed.
    always_comb begin
        merged = bank_q;
        if (state == FILL) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (lane_idx_t'(k) == cnt) begin
                    merged[k] = in_data;
                end else if (lane_idx_t'(k) > cnt) begin
                    merged[k] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= FILL;
            cnt          <= '0;
            held_count   <= '0;
            lanes        <= '0;
            launch_count <= '0;
            launch_q     <= 1'b0;
            sv_pipe      <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            held_count <= held_count_next;
            launch_q   <= transfer;
            sv_pipe[0] <= launch_q;
            for (int unsigned i = 1; i < TREE_LATENCY; i++) begin
                sv_pipe[i] <= sv_pipe[i-1];
            end
            if (transfer) begin
                lanes        <= merged;
                launch_count <= count_next;
            end
        end
    end

    assign launch    = launch_q;
    assign sum_valid = sv_pipe[TREE_LATENCY-1];

    assign isum0_0_0_0 = lanes[0];
    assign isum0_0_0_1 = lanes[1];
    assign isum0_0_1_0 = lanes[2];
    assign isum0_0_1_1 = lanes[3];
    assign isum0_1_0_0 = lanes[4];
    assign isum0_1_0_1 = lanes[5];
    assign isum0_1_1_0 = lanes[6];
    assign isum0_1_1_1 = lanes[7];

endmodule

// File: tb/tb_adder_tree_operand_loader.sv
// Directed bench for adder_tree_operand_loader: cycle vector table plus hand-written corner sequences.
module tb_adder_tree_operand_loader;

    localparam int unsigned W = 128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         stall;
    logic [W-1:0] lane [8];
    logic         launch;
    logic [3:0]   launch_count;
    logic         sum_valid;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    adder_tree_operand_loader #(
        .ADDER_WIDTH  (W),
        .LANES        (8),
        .TREE_LATENCY (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .stall        (stall),
        .isum0_0_0_0  (lane[0]),
        .isum0_0_0_1  (lane[1]),
        .isum0_0_1_0  (lane[2]),
        .isum0_0_1_1  (lane[3]),
        .isum0_1_0_0  (lane[4]),
        .isum0_1_0_1  (lane[5]),
        .isum0_1_1_0  (lane[6]),
        .isum0_1_1_1  (lane[7]),
        .launch       (launch),
        .launch_count (launch_count),
        .sum_valid    (sum_valid)
    );

    typedef struct {
        logic         valid;
        logic         last;
        logic         stl;
        logic [W-1:0] data;
        logic         exp_ready;
        logic         exp_launch;
        logic [3:0]   exp_count;
        logic         exp_sv;
        logic [W-1:0] exp_lane0;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(input logic v, input logic l, input logic s, input logic [W-1:0] d,
                                input logic r, input logic la, input logic [3:0] c,
                                input logic sv, input logic [W-1:0] l0);
        vec_t t;
        t.valid = v; t.last = l; t.stl = s; t.data = d;
        t.exp_ready = r; t.exp_launch = la; t.exp_count = c; t.exp_sv = sv; t.exp_lane0 = l0;
        return t;
    endfunction

    task automatic chk(input string name, input logic [130:0] act, input logic [130:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs after the falling edge, then sample just after the next rising edge.
    task automatic cyc(input logic r, input logic v, input logic [W-1:0] d, input logic l, input logic s);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        stall    = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [130:0] tree_sum();
        logic [130:0] s = '0;
        for (int i = 0; i < 8; i++) s += {3'b000, lane[i]};
        return s;
    endfunction

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            cyc(1'b1, tbl[i].valid, tbl[i].data, tbl[i].last, tbl[i].stl);
            chk($sformatf("row%0d in_ready", i), {130'b0, in_ready}, {130'b0, tbl[i].exp_ready});
            chk($sformatf("row%0d launch", i), {130'b0, launch}, {130'b0, tbl[i].exp_launch});
            chk($sformatf("row%0d launch_count", i), {127'b0, launch_count}, {127'b0, tbl[i].exp_count});
            chk($sformatf("row%0d sum_valid", i), {130'b0, sum_valid}, {130'b0, tbl[i].exp_sv});
            chk($sformatf("row%0d lane0", i), {3'b0, lane[0]}, {3'b0, tbl[i].exp_lane0});
        end
    endtask

    initial begin
        logic [W-1:0] ones;
        ones     = '1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        stall    = 1'b0;

        // Full frame 1..8, then idle to watch sum_valid trail launch by two cycles.
        for (int k = 1; k <= 8; k++) begin
            tbl[k-1] = mk(1'b1, k == 8, 1'b0, W'(k), 1'b1, k == 8,
                          (k == 8) ? 4'd8 : 4'd0, 1'b0, (k == 8) ? W'(1) : W'(0));
        end
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd8, 1'b0, W'(1));
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd8, 1'b1, W'(1));
        tbl[10] = mk(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd8, 1'b0, W'(1));
        // Back-to-back single-word frames.
        tbl[11] = mk(1'b1, 1'b1, 1'b0, W'(10), 1'b1, 1'b1, 4'd1, 1'b0, W'(10));
        tbl[12] = mk(1'b1, 1'b1, 1'b0, W'(20), 1'b1, 1'b1, 4'd1, 1'b0, W'(20));
        tbl[13] = mk(1'b1, 1'b1, 1'b0, W'(30), 1'b1, 1'b1, 4'd1, 1'b1, W'(30));
        tbl[14] = mk(1'b1, 1'b1, 1'b0, W'(40), 1'b1, 1'b1, 4'd1, 1'b1, W'(40));
        tbl[15] = mk(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd1, 1'b1, W'(40));
        tbl[16] = mk(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd1, 1'b1, W'(40));
        tbl[17] = mk(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 4'd1, 1'b0, W'(40));

        // Reset state.
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, W'(99), 1'b1, 1'b0);
        chk("reset in_ready", {130'b0, in_ready}, 131'd0);
        chk("reset launch", {130'b0, launch}, 131'd0);
        chk("reset launch_count", {127'b0, launch_count}, 131'd0);
        chk("reset sum_valid", {130'b0, sum_valid}, 131'd0);
        chk("reset lanes sum", tree_sum(), 131'd0);

        run_rows(0, 10);
        for (int k = 0; k < 8; k++) chk($sformatf("full lane%0d", k), {3'b0, lane[k]}, 131'(k + 1));
        chk("full tree sum", tree_sum(), 131'd36);

        run_rows(11, 17);
        for (int k = 1; k < 8; k++) chk($sformatf("single lane%0d", k), {3'b0, lane[k]}, 131'd0);

        // Partial frame: all-ones plus one.
        cyc(1'b1, 1'b1, ones, 1'b0, 1'b0);
        chk("partial w0 launch", {130'b0, launch}, 131'd0);
        cyc(1'b1, 1'b1, W'(1), 1'b1, 1'b0);
        chk("partial launch", {130'b0, launch}, 131'd1);
        chk("partial launch_count", {127'b0, launch_count}, 131'd2);
        chk("partial lane0", {3'b0, lane[0]}, {3'b0, ones});
        chk("partial lane1", {3'b0, lane[1]}, 131'd1);
        for (int k = 2; k < 8; k++) chk($sformatf("partial lane%0d", k), {3'b0, lane[k]}, 131'd0);
        chk("partial tree sum", tree_sum(), 131'd1 << 128);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);

        // Stall held through the fill is ignored; at the close it parks the bank in FULL.
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b1, 1'b1, W'(100 + k), 1'b0, 1'b1);
            chk($sformatf("midfill stall ready w%0d", k), {130'b0, in_ready}, 131'd1);
        end
        cyc(1'b1, 1'b1, W'(108), 1'b1, 1'b1);
        chk("stall close ready", {130'b0, in_ready}, 131'd0);
        chk("stall close launch", {130'b0, launch}, 131'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 1'b1, W'('hDEAD), 1'b0, 1'b1);
            chk($sformatf("full ready c%0d", k), {130'b0, in_ready}, 131'd0);
            chk($sformatf("full launch c%0d", k), {130'b0, launch}, 131'd0);
            chk($sformatf("full count c%0d", k), {127'b0, launch_count}, 131'd2);
        end
        cyc(1'b1, 1'b1, W'('hDEAD), 1'b0, 1'b0);
        chk("stall exit launch", {130'b0, launch}, 131'd1);
        chk("stall exit ready", {130'b0, in_ready}, 131'd1);
        chk("stall exit count", {127'b0, launch_count}, 131'd8);
        for (int k = 0; k < 8; k++) chk($sformatf("stall lane%0d", k), {3'b0, lane[k]}, 131'(101 + k));
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
        chk("stall post launch", {130'b0, launch}, 131'd0);

        // Reset right after a launch clears the in-flight sum_valid.
        cyc(1'b1, 1'b1, W'(55), 1'b1, 1'b0);
        chk("inflight launch", {130'b0, launch}, 131'd1);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("inflight rst ready", {130'b0, in_ready}, 131'd0);
        chk("inflight rst launch", {130'b0, launch}, 131'd0);
        chk("inflight rst lane0", {3'b0, lane[0]}, 131'd0);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
            chk($sformatf("inflight sum_valid c%0d", k), {130'b0, sum_valid}, 131'd0);
        end

        // Reset mid-frame after three accepts, then a clean full frame.
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, W'(71 + k), 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("midframe rst launch", {130'b0, launch}, 131'd0);
        chk("midframe rst lanes", tree_sum(), 131'd0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 1'b1, W'(201 + k), k == 7, 1'b0);
            if (k < 7) chk($sformatf("post rst launch w%0d", k), {130'b0, launch}, 131'd0);
        end
        chk("post rst launch", {130'b0, launch}, 131'd1);
        chk("post rst count", {127'b0, launch_count}, 131'd8);
        chk("post rst lane0", {3'b0, lane[0]}, 131'd201);
        chk("post rst lane7", {3'b0, lane[7]}, 131'd208);
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
